// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture engine: FSM states,
// pixel-format codes and the counter-width calculation.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cam_state_t;

    localparam logic FMT_RGB444 = 1'b0;
    localparam logic FMT_RGB565 = 1'b1;

    // Bits needed to hold 0..maxVal inclusive; counters must reach the limit itself.
    function automatic int cntWidth(input int maxVal);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) <= maxVal) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Frame-buffer write port: registered address, data and one-cycle strobe.
interface cam_capture_if #(
    parameter int AW = 15,
    parameter int DW = 3
);
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;

    modport master (
        output mem_px_addr,
        output mem_px_data,
        output px_wr
    );

    modport slave (
        input mem_px_addr,
        input mem_px_data,
        input px_wr
    );
endinterface

// File: rtl/cam_px_pack.sv
// Combinational pixel packer: two camera bytes to {R,G,B}, keeping the
// top CW bits of each colour field.
module cam_px_pack
    import cam_pkg::*;
#(
    parameter int CW = 1
) (
    input  logic [7:0]      byte0,
    input  logic [7:0]      byte1,
    input  logic            fmt_r,
    output logic [3*CW-1:0] pixel
);

    logic [3:0] w_r444;
    logic [3:0] w_g444;
    logic [3:0] w_b444;
    logic [4:0] w_r565;
    logic [5:0] w_g565;
    logic [4:0] w_b565;
    logic       w_unusedBits;

    assign w_r444 = byte0[3:0];
    assign w_g444 = byte1[7:4];
    assign w_b444 = byte1[3:0];
    assign w_r565 = byte0[7:3];
    assign w_g565 = {byte0[2:0], byte1[7:5]};
    assign w_b565 = byte1[4:0];

    // Low field bits are discarded by design at small CW.
    assign w_unusedBits = ^{w_r444, w_g444, w_b444, w_r565, w_g565, w_b565};

    always_comb begin
        pixel = {w_r444[3 -: CW], w_g444[3 -: CW], w_b444[3 -: CW]};
        if (fmt_r == FMT_RGB565) begin
            pixel = {w_r565[4 -: CW], w_g565[5 -: CW], w_b565[4 -: CW]};
        end
    end

endmodule

// File: rtl/cam_capture.sv
// Camera capture engine: turns the two-bytes-per-pixel sensor stream into
// packed pixels written line-aligned into the frame buffer, in the PCLK domain.
module cam_capture
    import cam_pkg::*;
#(
    parameter int AW      = 15,
    parameter int CW      = 1,
    parameter int DW      = 3 * CW,
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120
) (
    input  logic       PCLK,
    input  logic       rst,
    input  logic [7:0] D,
    input  logic       VSYNC,
    input  logic       HREF,
    input  logic       fmt,
    cam_capture_if.master memIf,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int COL_W  = cntWidth(H_PIX);
    localparam int LINE_W = cntWidth(V_LINES);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_PIX);
    localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(V_LINES);
    localparam logic [AW-1:0]     LINE_STEP = AW'(H_PIX);

    cam_state_t        r_state, w_nextState;
    logic              r_vsyncQ, r_hrefQ;
    logic              r_fmt, w_fmt;
    logic              r_phase, w_phase;
    logic [7:0]        r_byte0, w_byte0;
    logic [COL_W-1:0]  r_col, w_col;
    logic [LINE_W-1:0] r_line, w_line;
    logic [LINE_W-1:0] w_lineNext;
    logic [AW-1:0]     r_lineBase, w_lineBase;
    logic [AW-1:0]     r_addr, w_addr;
    logic [DW-1:0]     r_data, w_data;
    logic              r_wr, w_wr;
    logic              r_frameErr, w_frameErr;
    logic              w_frameStart, w_hrefFall;
    logic [DW-1:0]     w_pixel;

    cam_px_pack #(.CW(CW)) u_pack (
        .byte0 (r_byte0),
        .byte1 (D),
        .fmt_r (r_fmt),
        .pixel (w_pixel)
    );

    assign w_frameStart = r_vsyncQ & ~VSYNC;
    assign w_hrefFall   = r_hrefQ & ~HREF;
    assign w_lineNext   = r_line + 1'b1;

    // State and datapath registers; a running line base replaces line*H_PIX.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vsyncQ   <= 1'b0;
            r_hrefQ    <= 1'b0;
            r_fmt      <= 1'b0;
            r_phase    <= 1'b0;
            r_byte0    <= '0;
            r_col      <= '0;
            r_line     <= '0;
            r_lineBase <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_vsyncQ   <= VSYNC;
            r_hrefQ    <= HREF;
            r_fmt      <= w_fmt;
            r_phase    <= w_phase;
            r_byte0    <= w_byte0;
            r_col      <= w_col;
            r_line     <= w_line;
            r_lineBase <= w_lineBase;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_wr       <= w_wr;
            r_frameErr <= w_frameErr;
        end
    end

    // Next-state logic; an early VSYNC wins over a byte in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_fmt       = r_fmt;
        w_phase     = r_phase;
        w_byte0     = r_byte0;
        w_col       = r_col;
        w_line      = r_line;
        w_lineBase  = r_lineBase;
        w_addr      = r_addr;
        w_data      = r_data;
        w_wr        = 1'b0;
        w_frameErr  = r_frameErr;

        unique case (r_state)
            ST_IDLE: begin
                if (w_frameStart) begin
                    w_fmt       = fmt;
                    w_frameErr  = 1'b0;
                    w_phase     = 1'b0;
                    w_col       = '0;
                    w_line      = '0;
                    w_lineBase  = '0;
                    w_nextState = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (VSYNC) begin
                    w_frameErr  = 1'b1;
                    w_nextState = ST_DONE;
                end else if (HREF) begin
                    if (!r_phase) begin
                        w_byte0 = D;
                        w_phase = 1'b1;
                    end else begin
                        w_phase = 1'b0;
                        if (r_col < COL_END) begin
                            w_wr   = 1'b1;
                            w_addr = r_lineBase + AW'(r_col);
                            w_data = w_pixel;
                            w_col  = r_col + 1'b1;
                        end else begin
                            w_frameErr = 1'b1;
                        end
                    end
                end else if (w_hrefFall) begin
                    if ((r_col != COL_END) || r_phase) w_frameErr = 1'b1;
                    w_col      = '0;
                    w_phase    = 1'b0;
                    w_line     = w_lineNext;
                    w_lineBase = r_lineBase + LINE_STEP;
                    if (w_lineNext == LINE_END) w_nextState = ST_DONE;
                end
            end

            ST_DONE: begin
                w_nextState = ST_IDLE;
            end

            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign memIf.mem_px_addr = r_addr;
    assign memIf.mem_px_data = r_data;
    assign memIf.px_wr       = r_wr;
    assign busy              = (r_state == ST_CAPTURE);
    assign frame_done        = (r_state == ST_DONE);
    assign frame_err         = r_frameErr;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: two instances (CW=1 and CW=4) share one
// camera stream on a 4x2 frame; writes are logged and compared per frame.
module tb_cam_capture;
    import cam_pkg::*;

    logic       PCLK = 1'b0;
    logic       rst;
    logic [7:0] D;
    logic       VSYNC;
    logic       HREF;
    logic       fmtIn;

    logic busy1, frameDone1, frameErr1;
    logic busy4, frameDone4, frameErr4;

    int total = 0;
    int bad   = 0;

    cam_capture_if #(.AW(4), .DW(3))  memIf1 ();
    cam_capture_if #(.AW(4), .DW(12)) memIf4 ();

    cam_capture #(.AW(4), .CW(1), .H_PIX(4), .V_LINES(2)) dut1 (
        .PCLK(PCLK), .rst(rst), .D(D), .VSYNC(VSYNC), .HREF(HREF), .fmt(fmtIn),
        .memIf(memIf1), .busy(busy1), .frame_done(frameDone1), .frame_err(frameErr1)
    );

    cam_capture #(.AW(4), .CW(4), .H_PIX(4), .V_LINES(2)) dut4 (
        .PCLK(PCLK), .rst(rst), .D(D), .VSYNC(VSYNC), .HREF(HREF), .fmt(fmtIn),
        .memIf(memIf4), .busy(busy4), .frame_done(frameDone4), .frame_err(frameErr4)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        fmt;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [2:0]  exp1;
        logic [11:0] exp4;
    } vec_t;

    vec_t vecs[6];

    logic [3:0]  addr1[$];
    logic [2:0]  data1[$];
    logic [3:0]  addr4[$];
    logic [11:0] data4[$];
    int   doneCnt1, doneCnt4;
    logic errAtDone1, errAtDone4;

    // Write and frame-done logger, sampled mid-cycle.
    always @(negedge PCLK) begin
        if (memIf1.px_wr) begin
            addr1.push_back(memIf1.mem_px_addr);
            data1.push_back(memIf1.mem_px_data);
        end
        if (memIf4.px_wr) begin
            addr4.push_back(memIf4.mem_px_addr);
            data4.push_back(memIf4.mem_px_data);
        end
        if (frameDone1) begin
            doneCnt1++;
            errAtDone1 = frameErr1;
        end
        if (frameDone4) begin
            doneCnt4++;
            errAtDone4 = frameErr4;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge PCLK);
        #1;
        VSYNC = vs;
        HREF  = hr;
        D     = d;
    endtask

    task automatic clearLog();
        addr1.delete();
        data1.delete();
        addr4.delete();
        data4.delete();
        doneCnt1   = 0;
        doneCnt4   = 0;
        errAtDone1 = 1'b0;
        errAtDone4 = 1'b0;
    endtask

    task automatic startFrame(input logic f);
        fmtIn = f;
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendPixel(input logic [7:0] b0, input logic [7:0] b1);
        applyStimulus(1'b0, 1'b1, b0);
        applyStimulus(1'b0, 1'b1, b1);
    endtask

    task automatic sendLine(input int n, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) sendPixel(b0, b1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic idleCycles(input int n, input logic vs);
        for (int i = 0; i < n; i++) applyStimulus(vs, 1'b0, 8'h00);
    endtask

    task automatic checkFrame(input string tag, input int n, input int expAddr[8],
                              input logic [2:0] e1, input logic [11:0] e4, input logic eErr);
        checkOutput({tag, " wrCount1"}, addr1.size(), n);
        checkOutput({tag, " wrCount4"}, addr4.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < addr1.size()) begin
                checkOutput($sformatf("%s addr1[%0d]", tag, i), addr1[i], expAddr[i]);
                checkOutput($sformatf("%s data1[%0d]", tag, i), data1[i], e1);
            end
            if (i < addr4.size()) begin
                checkOutput($sformatf("%s addr4[%0d]", tag, i), addr4[i], expAddr[i]);
                checkOutput($sformatf("%s data4[%0d]", tag, i), data4[i], e4);
            end
        end
        checkOutput({tag, " doneCnt1"}, doneCnt1, 1);
        checkOutput({tag, " doneCnt4"}, doneCnt4, 1);
        checkOutput({tag, " err1"}, errAtDone1, eErr);
        checkOutput({tag, " err4"}, errAtDone4, eErr);
        checkOutput({tag, " busyAfter"}, busy1, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " px_wr"}, memIf1.px_wr, 1'b0);
        checkOutput({tag, " addr"},  memIf1.mem_px_addr, 4'h0);
        checkOutput({tag, " data1"}, memIf1.mem_px_data, 3'h0);
        checkOutput({tag, " data4"}, memIf4.mem_px_data, 12'h000);
        checkOutput({tag, " busy"},  busy1, 1'b0);
        checkOutput({tag, " done"},  frameDone1, 1'b0);
        checkOutput({tag, " err"},   frameErr1, 1'b0);
    endtask

    int seqAddr[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
    int shortAddr[8] = '{0, 1, 2, 4, 5, 6, 7, 0};

    initial begin
        vecs[0] = '{fmt: FMT_RGB444, b0: 8'h0F, b1: 8'h80, exp1: 3'b110, exp4: 12'hF80};
        vecs[1] = '{fmt: FMT_RGB565, b0: 8'hF8, b1: 8'h1F, exp1: 3'b101, exp4: 12'hF0F};
        vecs[2] = '{fmt: FMT_RGB444, b0: 8'hA5, b1: 8'h3C, exp1: 3'b001, exp4: 12'h53C};
        vecs[3] = '{fmt: FMT_RGB565, b0: 8'h07, b1: 8'hE0, exp1: 3'b010, exp4: 12'h0F0};
        vecs[4] = '{fmt: FMT_RGB565, b0: 8'h84, b1: 8'h21, exp1: 3'b110, exp4: 12'h880};
        vecs[5] = '{fmt: FMT_RGB444, b0: 8'h48, b1: 8'hC7, exp1: 3'b110, exp4: 12'h8C7};

        rst   = 1'b1;
        VSYNC = 1'b0;
        HREF  = 1'b0;
        D     = 8'h00;
        fmtIn = 1'b0;
        clearLog();
        repeat (3) @(posedge PCLK);
        #2;
        checkAllZero("reset");
        rst = 1'b0;
        idleCycles(2, 1'b0);

        // Full frames, one table entry per frame.
        for (int v = 0; v < 6; v++) begin
            clearLog();
            startFrame(vecs[v].fmt);
            sendLine(4, vecs[v].b0, vecs[v].b1);
            sendLine(4, vecs[v].b0, vecs[v].b1);
            idleCycles(3, 1'b0);
            checkFrame($sformatf("vec%0d", v), 8, seqAddr, vecs[v].exp1, vecs[v].exp4, 1'b0);
        end

        // Short first line: line 1 still starts at address 4.
        clearLog();
        startFrame(FMT_RGB444);
        sendLine(3, 8'h0F, 8'h80);
        sendLine(4, 8'h0F, 8'h80);
        idleCycles(3, 1'b0);
        checkFrame("short", 7, shortAddr, 3'b110, 12'hF80, 1'b1);

        // Early VSYNC after 5 pixels, then VSYNC held high with HREF activity.
        clearLog();
        startFrame(FMT_RGB444);
        sendLine(4, 8'h0F, 8'h80);
        sendPixel(8'h0F, 8'h80);
        applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h0F);
            applyStimulus(1'b1, 1'b1, 8'h80);
        end
        idleCycles(2, 1'b1);
        checkFrame("early", 5, seqAddr, 3'b110, 12'hF80, 1'b1);

        // Reset after the third write of a frame.
        clearLog();
        startFrame(FMT_RGB444);
        for (int i = 0; i < 3; i++) sendPixel(8'h0F, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h0F);
        @(negedge PCLK);
        #1;
        checkOutput("preReset px_wr", memIf1.px_wr, 1'b1);
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        checkOutput("midReset wrCount", addr1.size(), 3);
        @(negedge PCLK);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) sendPixel(8'h0F, 8'h80);
        idleCycles(3, 1'b0);
        checkOutput("postReset wrCount", addr1.size(), 3);
        checkOutput("postReset busy", busy1, 1'b0);
        checkOutput("postReset done", doneCnt1, 0);
        clearLog();
        startFrame(FMT_RGB565);
        sendLine(4, 8'hF8, 8'h1F);
        sendLine(4, 8'hF8, 8'h1F);
        idleCycles(3, 1'b0);
        checkFrame("afterReset", 8, seqAddr, 3'b101, 12'hF0F, 1'b0);

        // Line overflow with a mid-frame fmt change that must be ignored.
        clearLog();
        startFrame(FMT_RGB444);
        sendPixel(8'h0F, 8'h80);
        sendPixel(8'h0F, 8'h80);
        fmtIn = FMT_RGB565;
        sendLine(3, 8'h0F, 8'h80);
        sendLine(4, 8'h0F, 8'h80);
        idleCycles(3, 1'b0);
        checkFrame("overflow", 8, seqAddr, 3'b110, 12'hF80, 1'b1);
        fmtIn = FMT_RGB444;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
# cam_capture

Parametrised camera capture engine. It converts the 8-bit, two-bytes-per-pixel stream from the OV7670-class sensor into packed RGB pixels of CW bits per channel. It writes them into the frame-buffer RAM with line-aligned addressing, and reports frame completion and framing errors. It sits between the camera pins and the dual-port frame buffer, in the PCLK domain.

## Interface
- AW, 15: frame-buffer address width; must satisfy 2^AW ≥ H_PIX*V_LINES.
- CW, 1: output bits per colour channel, 1..4.
- DW, 3*CW: pixel data width, packed as {R,G,B}, R in the MSBs.
- H_PIX, 160: pixels per line.
- V_LINES, 120: lines per frame.
- PCLK  in  1  pixel clock; every register in the block is clocked on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- D  in  8  camera data byte.
- VSYNC  in  1  frame sync; high between frames.
- HREF  in  1  line valid; a byte is valid when HREF=1 and VSYNC=0.
- fmt  in  1  pixel format: 0 = RGB444, 1 = RGB565. Sampled only at frame start.
- mem_px_addr  out  AW  write address.
- mem_px_data  out  DW  write data.
- px_wr  out  1  one-cycle write strobe.
- busy  out  1  high while a frame is being captured.
- frame_done  out  1  one-cycle pulse at the end of every frame attempt.
- frame_err  out  1  sticky per frame: short or long line, early VSYNC, or line overflow. Cleared at the next frame start.

## Operation
- Reset values: all outputs 0; state IDLE; byte phase 0; column and line counters 0; vsync_q 0.
- vsync_q holds the VSYNC value from the previous cycle. Frame start = vsync_q=1 and VSYNC=0. href_q is the same register for HREF.
- **IDLE**
  - px_wr=0, busy=0.
  - On frame start: latch fmt into fmt_r, clear frame_err, clear the counters, go to CAPTURE.
- **CAPTURE** (busy=1)
  - Valid byte, phase 0: store D in byte0; phase becomes 1.
  - Valid byte, phase 1: build the pixel from byte0 and D; phase becomes 0.
    - If col < H_PIX: write the pixel at address line*H_PIX + col, then col increments.
    - If col = H_PIX: drop the pixel and set frame_err.
  - HREF falling edge (href_q=1, HREF=0):
    - If col ≠ H_PIX or phase=1, set frame_err.
    - col becomes 0, phase becomes 0, line increments.
    - If the new line value equals V_LINES, go to DONE.
  - VSYNC=1 while in CAPTURE (early end of frame): set frame_err, go to DONE. This check has priority over a byte in the same cycle.
- **DONE**
  - frame_done=1 for exactly one cycle, then go to IDLE.
  - A frame start is not detected in DONE. The detector re-arms in IDLE, because vsync_q tracks VSYNC continuously.
- Pixel conversion; each channel keeps the top CW bits of its field:
  - RGB444: R=byte0[3:0], G=D[7:4], B=D[3:0].
  - RGB565: R=byte0[7:3], G={byte0[2:0],D[7:5]} (6 bits), B=D[4:0].
- Addressing: address = line*H_PIX + col, computed as a running line base plus col, with no multiplier. A short line does not shift later lines. The address never exceeds H_PIX*V_LINES-1.
- fmt changes during a frame have no effect until the next frame start.
- Reset in the middle of a frame: everything returns to reset values, and no write occurs in the reset cycle. Capture resumes only after the next VSYNC falling edge.

## Timing
- px_wr, mem_px_addr and mem_px_data are registered. They are valid together in the cycle after the second byte is sampled, so latency from the byte-1 edge to the write strobe is 1 cycle.
- mem_px_addr and mem_px_data hold their values between writes.
- px_wr is never high on two consecutive cycles, because each pixel takes two bytes.
- frame_done rises 1 cycle after the final HREF fall or the early VSYNC rise is sampled. frame_err is valid no later than frame_done.
- The first valid byte can arrive in the cycle directly after the frame-start cycle.

## Structure
- Package cam_pkg holds:
  - the state encoding (IDLE, CAPTURE, DONE);
  - the format constants FMT_RGB444=0 and FMT_RGB565=1;
  - a function that computes the counter widths from H_PIX and V_LINES.
- Sub-module cam_px_pack, purely combinational: inputs byte0, byte1, fmt_r; output DW-bit packed pixel, with CW as a parameter.

## Test plan
- **RGB444 frame.** H_PIX=4, V_LINES=2, CW=1, fmt=0. Send 2 lines of 4 pixels, each pixel bytes 0x0F then 0x80. Expect 8 writes with data 3'b110 at addresses 0..7, one frame_done pulse, frame_err=0.
- **RGB565 at CW=4.** Pixel bytes 0xF8 then 0x1F. Expect data 12'hF0F: R=F, G=0, B=F.
- **Short line.** Line 0 carries 3 pixels. Expect line 1 to start at address 4, frame_err=1, and 7 writes in total.
- **Early VSYNC.** VSYNC rises after 5 pixels. Expect 5 writes, frame_done pulse, frame_err=1, busy=0, and no writes until the next VSYNC fall.
- **Reset mid-frame.** Assert rst after 3 writes. Expect all outputs 0 immediately and no writes until a new VSYNC fall. The next frame starts at address 0.
- **Line overflow.** Change fmt in the middle of a frame (no effect on the current frame), and send 5 pixels on a 4-pixel line. Expect the 5th pixel dropped with no write, frame_err=1, and address 4 reserved for line 1.
